imem_fetch_ctrl: RTL and testbench

Fetch controller sequencing a synchronous-read, word-addressed instruction memory. It owns the program counter and issues one read per cycle. Fetched words are buffered and presented to decode on a valid/ready handshake. It also arbitrates the memory port between fetch and a boot loader that writes the program image before execution starts.

---
 rtl/imem_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller for a synchronous-read instruction memory.
// Owns the PC, buffers fetched words in a 2-deep skid FIFO, and shares the port with a boot loader.
module imem_fetch_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  load_en,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [31:0]           out_pc,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  running,
    output logic                  align_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]            state;
    logic [31:0]           fetch_pc;
    logic [31:0]           infl_pc;
    logic                  infl;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] ins0, ins1;
    logic [31:0]           pc0, pc1;

    logic is_run, is_load, pop, push, redir, flush, issue;

    assign is_run  = (state == S_RUN);
    assign is_load = (state == S_LOAD);
    assign running = is_run;

    assign out_valid = (occ != 2'd0);
    assign out_instr = ins0;
    assign out_pc    = pc0;

    assign pop   = out_valid & out_ready;
    assign redir = is_run & ~load_en & redirect_valid;
    assign flush = is_run & (load_en | redirect_valid);
    // Killing infl on flush drops any read already issued to the old stream.
    assign push  = infl & ~flush;
    assign issue = is_run & ~flush &
                   ((({1'b0, occ} + {2'b00, infl}) < 3'd2) | pop);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (is_load) begin
            mem_en    = load_we;
            mem_we    = load_we;
            mem_addr  = load_addr;
            mem_wdata = load_data;
        end else if (is_run) begin
            mem_en   = issue;
            mem_addr = fetch_pc[ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            infl      <= 1'b0;
            infl_pc   <= '0;
            align_err <= 1'b0;
        end else begin
            infl <= issue;
            if (issue)
                infl_pc <= fetch_pc;
            if (redir && (redirect_pc[1:0] != 2'b00))
                align_err <= 1'b1;

            if (is_load && !load_en)
                fetch_pc <= RESET_PC;
            else if (redir)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (issue)
                fetch_pc <= fetch_pc + 32'd4;

            case (state)
                S_IDLE: begin
                    if (load_en)
                        state <= S_LOAD;
                    else if (start)
                        state <= S_RUN;
                end
                S_LOAD: begin
                    if (!load_en)
                        state <= S_IDLE;
                end
                S_RUN: begin
                    if (load_en)
                        state <= S_LOAD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            ins0 <= '0;
            ins1 <= '0;
            pc0  <= '0;
            pc1  <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        ins0 <= mem_rdata;
                        pc0  <= infl_pc;
                    end else begin
                        ins1 <= mem_rdata;
                        pc1  <= infl_pc;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ins0 <= ins1;
                    pc0  <= pc1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        ins0 <= ins1;
                        pc0  <= pc1;
                        ins1 <= mem_rdata;
                        pc1  <= infl_pc;
                    end else begin
                        ins0 <= mem_rdata;
                        pc0  <= infl_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a synchronous-read memory model.
// Inputs change and outputs are checked just after the falling edge.
module tb_imem_fetch_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, load_en, load_we;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_instr;
    logic [31:0]   out_pc;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          running, align_err;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total  = 0;
    int passed = 0;
    int reads;
    int bad;

    localparam logic [31:0] W0   = 32'h0000_0013;
    localparam logic [31:0] W1   = 32'h0010_0093;
    localparam logic [31:0] W2   = 32'h0020_0113;
    localparam logic [31:0] W16  = 32'hA000_0010;
    localparam logic [31:0] W255 = 32'hB000_00FF;

    logic [AW-1:0] ld_a [5];
    logic [31:0]   ld_d [5];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    imem_fetch_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .load_en       (load_en),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .running       (running),
        .align_err     (align_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        mem_rdata = '0;
        ld_a[0] = 8'd0;   ld_d[0] = W0;
        ld_a[1] = 8'd1;   ld_d[1] = W1;
        ld_a[2] = 8'd2;   ld_d[2] = W2;
        ld_a[3] = 8'd16;  ld_d[3] = W16;
        ld_a[4] = 8'd255; ld_d[4] = W255;

        rst_n = 1'b0;
        start = 1'b0;
        load_en = 1'b0;
        load_we = 1'b0;
        load_addr = '0;
        load_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_memen", mem_en, 0);
        chk("rst_run", running, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_align", align_err, 0);

        nxt(); rst_n = 1'b1;
        nxt(); load_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nxt();
            load_we = 1'b1;
            load_addr = ld_a[i];
            load_data = ld_d[i];
            #1;
            chk("ld_we", mem_we, 1);
            chk("ld_addr", mem_addr, ld_a[i]);
            chk("ld_data", mem_wdata, ld_d[i]);
        end
        nxt(); load_we = 1'b0; load_en = 1'b0; #1;
        chk("ld_off_en", mem_en, 0);
        nxt(); start = 1'b1; #1;
        chk("idle_run", running, 0);

        // T: first RUN cycle
        nxt(); start = 1'b0; out_ready = 1'b1; #1;
        chk("t0_run", running, 1);
        chk("t0_memen", mem_en, 1);
        chk("t0_addr", mem_addr, 0);
        chk("t0_valid", out_valid, 0);
        nxt(); #1;
        chk("t1_valid", out_valid, 0);
        nxt(); #1;
        chk("t2_valid", out_valid, 1);
        chk("t2_pc", out_pc, 32'h0);
        chk("t2_ins", out_instr, W0);
        nxt(); #1;
        chk("t3_pc", out_pc, 32'h4);
        chk("t3_ins", out_instr, W1);
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0; #1;
        chk("t4_pc", out_pc, 32'h8);
        chk("t4_ins", out_instr, W2);

        // Backpressure: restart at 0 with out_ready low
        nxt(); redirect_valid = 1'b0; #1;
        chk("bp_flush", out_valid, 0);
        chk("bp_addr", mem_addr, 0);
        reads = mem_en ? 1 : 0;
        bad = 0;
        for (int i = 2; i <= 7; i++) begin
            nxt(); #1;
            if (mem_en) reads++;
            if (i >= 3 && !(out_valid && out_pc == 32'h0 && out_instr == W0))
                bad++;
        end
        chk("bp_reads", reads, 2);
        chk("bp_stable", bad, 0);
        nxt(); out_ready = 1'b1; #1;
        chk("rel_v0", out_valid, 1);
        chk("rel_pc0", out_pc, 32'h0);
        nxt(); #1;
        chk("rel_pc4", out_pc, 32'h4);
        nxt(); out_ready = 1'b0; #1;
        chk("rel_v8", out_valid, 1);
        chk("rel_pc8", out_pc, 32'h8);
        nxt(); nxt(); nxt();

        // Redirect with two words buffered
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("rd_full", out_valid, 1);
        chk("rd_hold", out_pc, 32'h8);
        nxt(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        chk("rd_flush", out_valid, 0);
        chk("rd_memen", mem_en, 1);
        chk("rd_addr", mem_addr, 16);
        nxt(); #1;
        chk("rd_gap", out_valid, 0);
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
        chk("rd_valid", out_valid, 1);
        chk("rd_pc", out_pc, 32'h40);
        chk("rd_ins", out_instr, W16);
        chk("rd_align0", align_err, 0);

        // Misaligned redirect
        nxt(); redirect_valid = 1'b0; #1;
        chk("mis_flush", out_valid, 0);
        chk("mis_addr", mem_addr, 16);
        chk("mis_align", align_err, 1);
        nxt();
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h3FC; #1;
        chk("mis_pc", out_pc, 32'h40);
        chk("mis_ins", out_instr, W16);

        // Memory-address wrap
        nxt(); redirect_valid = 1'b0; #1;
        chk("wr_sticky", align_err, 1);
        chk("wr_addr", mem_addr, 255);
        nxt();
        nxt(); #1;
        chk("wr_pc0", out_pc, 32'h3FC);
        chk("wr_ins0", out_instr, W255);
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk("wr_pc1", out_pc, 32'h400);
        chk("wr_ins1", out_instr, W0);

        // 32-bit PC wrap
        nxt(); redirect_valid = 1'b0;
        nxt();
        nxt(); #1;
        chk("pw_pc0", out_pc, 32'hFFFF_FFFC);
        chk("pw_ins0", out_instr, W255);
        nxt(); load_en = 1'b1; #1;
        chk("pw_pc1", out_pc, 32'h0);
        chk("pw_ins1", out_instr, W0);

        // Load session mid-run
        nxt(); load_en = 1'b0; #1;
        chk("lm_valid", out_valid, 0);
        chk("lm_run", running, 0);
        chk("lm_memen", mem_en, 0);
        nxt(); start = 1'b1; #1;
        chk("lm_idle_v", out_valid, 0);
        nxt(); start = 1'b0; #1;
        chk("lm_t0_en", mem_en, 1);
        chk("lm_t0_addr", mem_addr, 0);
        chk("lm_t0_v", out_valid, 0);
        nxt(); #1;
        chk("lm_t1_v", out_valid, 0);
        nxt(); #1;
        chk("lm_t2_v", out_valid, 1);
        chk("lm_t2_pc", out_pc, 32'h0);
        nxt(); #1;
        chk("lm_t3_pc", out_pc, 32'h4);

        // Asynchronous reset mid-run
        #1; rst_n = 1'b0; #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_run", running, 0);
        chk("ar_memen", mem_en, 0);
        chk("ar_pc", out_pc, 0);
        chk("ar_ins", out_instr, 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_align", align_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
